// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion, one schedule word per clock,
// round keys handed out over a valid/ready port, round 0 first.
`timescale 1ns/1ps
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] t, inv;
  // GF(2^8) inverse as x^254 followed by the affine map
  always_comb begin
    t = a_i;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gmul(t, t);
      inv = gmul(inv, t);
    end
    s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   key_size_i,
  input  logic [255:0] key_in_i,
  input  logic         rk_ready_i,
  output logic         rk_valid_o,
  output logic [127:0] rk_data_o,
  output logic [3:0]   rk_index_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);
  localparam logic [9:0] MAX_BITS = 10'(MAX_KEY_BITS);
  typedef enum logic {IDLE, GEN} state_t;
  state_t state_q, state_d;
  logic [1:0] ks_q;
  logic [255:0] key_q, key_sh;
  logic [5:0] i_q, tw;
  logic [2:0] j_q, j_d, back;
  logic [7:0] rcon_q;
  logic [7:0][31:0] win_q;
  logic rk_valid_q, err_q;
  logic [127:0] rk_data_q;
  logic [3:0] rk_index_q;
  logic [9:0] size_bits;
  logic bad, accept, stall, gen, last_hs, rot_step;
  logic [31:0] prev, sub_in, sub_out, temp, w_new;
  assign size_bits = 10'd128 + {2'b00, key_size_i, 6'd0};
  assign bad = key_size_i == 2'd3 || size_bits > MAX_BITS;
  assign accept = state_q == IDLE && start_i && !bad;
  assign back = ks_q == 2'd0 ? 3'd3 : ks_q == 2'd1 ? 3'd5 : 3'd7;
  assign tw = ks_q == 2'd0 ? 6'd44 : ks_q == 2'd1 ? 6'd52 : 6'd60;
  assign stall = rk_valid_q && !rk_ready_i;
  assign gen = state_q == GEN && i_q < tw && !stall;
  assign last_hs = state_q == GEN && i_q == tw && rk_valid_q && rk_ready_i;
  assign j_d = j_q == back ? 3'd0 : j_q + 3'd1;
  assign key_sh = key_q << {i_q[2:0], 5'd0};
  assign rot_step = j_q == 3'd0;
  assign prev = win_q[0];
  assign sub_in = rot_step ? {prev[23:0], prev[31:24]} : prev;
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(sub_in[8*g +: 8]), .s_o(sub_out[8*g +: 8]));
  end
  assign temp = rot_step ? sub_out ^ {rcon_q, 24'h0} : (ks_q == 2'd2 && j_q == 3'd4) ? sub_out : prev;
  assign w_new = i_q <= {3'd0, back} ? key_sh[255:224] : win_q[back] ^ temp;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = accept ? GEN : IDLE;
    else if (last_hs) state_d = IDLE;
  end
  always_comb begin
    busy_o = state_q == GEN;
    done_o = last_hs;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ks_q <= '0;
      key_q <= '0;
      i_q <= '0;
      j_q <= '0;
      rcon_q <= '0;
      win_q <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q <= '0;
      rk_index_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= state_q == IDLE && start_i && bad;
      if (accept) begin
        key_q <= key_in_i;
        ks_q <= key_size_i;
        i_q <= '0;
        j_q <= '0;
        rcon_q <= 8'h01;
      end else if (gen) begin
        i_q <= i_q + 6'd1;
        j_q <= j_d;
        win_q <= {win_q[6:0], w_new};
        if (i_q > {3'd0, back} && rot_step) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
      if (gen && i_q[1:0] == 2'd3) begin
        rk_valid_q <= 1'b1;
        rk_data_q <= {win_q[2], win_q[1], win_q[0], w_new};
        rk_index_q <= i_q[5:2];
      end else if (rk_ready_i) rk_valid_q <= 1'b0;
    end
  end
  assign rk_valid_o = rk_valid_q;
  assign rk_data_o = rk_data_q;
  assign rk_index_o = rk_index_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: scoreboard bench; a FIPS-197 style expansion model predicts every round key.
`timescale 1ns/1ps
module tb_aes_key_schedule;
  logic clk = 0, rst_n = 0, start = 0, rk_ready = 1;
  logic [1:0] key_size = 0;
  logic [255:0] key_in = 0;
  logic rk_valid, busy, done, err;
  logic [127:0] rk_data;
  logic [3:0] rk_index;
  logic rk_valid2, busy2, done2, err2;
  logic [127:0] rk_data2;
  logic [3:0] rk_index2;

  aes_key_schedule dut (.clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_size_i(key_size),
    .key_in_i(key_in), .rk_ready_i(rk_ready), .rk_valid_o(rk_valid), .rk_data_o(rk_data),
    .rk_index_o(rk_index), .busy_o(busy), .done_o(done), .err_o(err));
  aes_key_schedule #(.MAX_KEY_BITS(128)) dut128 (.clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .key_size_i(key_size), .key_in_i(key_in), .rk_ready_i(rk_ready), .rk_valid_o(rk_valid2),
    .rk_data_o(rk_data2), .rk_index_o(rk_index2), .busy_o(busy2), .done_o(done2), .err_o(err2));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] d;
    logic [3:0] idx;
    bit last;
    int at;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, hs = 0, hs_start = 0, hold = 0;
  bit rnd = 0;
  logic [7:0] sbox_t[256];
  logic [7:0] rcon_t[11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] exp_rk[15];

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box table from the multiplicative-generator walk (3 and its inverse)
  function automatic void build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  task automatic issue(input logic [255:0] k, input logic [1:0] s, input bit timed, input bit r);
    int nk, nr, ts;
    logic [31:0] w[60];
    logic [31:0] t;
    nk = 4 + 2 * int'(s);
    nr = nk + 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = k[255 - 32 * i -: 32];
      else begin
        t = w[i - 1];
        if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i / nk], 24'h0};
        else if (nk == 8 && i % 8 == 4) t = subw(t);
        w[i] = w[i - nk] ^ t;
      end
    end
    for (int q = 0; q <= nr; q++) exp_rk[q] = {w[4 * q], w[4 * q + 1], w[4 * q + 2], w[4 * q + 3]};
    hs_start = hs;
    @(posedge clk);
    #1 key_in = k;
    key_size = s;
    start = 1;
    rnd = r;
    @(posedge clk);
    #1 ts = cyc;
    start = 0;
    key_in = {8{$urandom}};
    for (int q = 0; q <= nr; q++) sb.push_back('{exp_rk[q], 4'(q), q == nr, timed ? ts + 4 * q + 4 : -1});
  endtask

  task automatic wait_done(input int n, input string name);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    chk({name, "_drain"}, 128'(sb.size()), 128'(0));
    chk({name, "_handshakes"}, 128'(hs - hs_start), 128'(n));
    sb.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!busy) hold = 0;
      if (!rnd) rk_ready = 1;
      else if (rk_valid && rk_index == 4'd3 && hold < 7) begin
        rk_ready = 0;
        hold++;
      end else rk_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [127:0] pd;
    logic [3:0] pi;
    bit sp;
    exp_t e;
    sp = 0;
    pd = 0;
    pi = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) sp = 0;
      else begin
        if (sp && rk_valid) begin
          chk("stall_data", rk_data, pd);
          chk("stall_index", 128'(rk_index), 128'(pi));
        end
        sp = rk_valid && !rk_ready;
        pd = rk_data;
        pi = rk_index;
        if (rk_valid && rk_ready) begin
          hs++;
          if (sb.size() == 0) chk("unexpected_rk_queue", 128'(sb.size()), 128'(1));
          else begin
            e = sb.pop_front();
            chk("rk_data", rk_data, e.d);
            chk("rk_index", 128'(rk_index), 128'(e.idx));
            chk("done_at_accept", 128'(done), 128'(e.last));
            if (e.at >= 0) chk("rk_timing", 128'(cyc), 128'(e.at));
          end
        end else chk("done_idle", 128'(done), 128'(0));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] k128, k192, k256;
    int c;
    build_sbox();
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_cafef00d};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h1122334455667788};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 128'(rk_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_err", 128'(err), 128'(0));
    chk("reset_data", rk_data, 128'(0));
    chk("reset_index", 128'(rk_index), 128'(0));
    rst_n = 1;

    issue(k128, 2'd0, 1, 0);
    chk("kat128_r0", exp_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("kat128_r1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat128_r10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    chk("busy_after_start", 128'(busy), 128'(1));
    repeat (10) @(posedge clk);
    #1 start = 1;
    key_size = 2'd3;
    @(posedge clk);
    #1 start = 0;
    key_size = 2'd0;
    @(negedge clk);
    chk("start_in_gen_err", 128'(err), 128'(0));
    chk("start_in_gen_busy", 128'(busy), 128'(1));
    wait_done(11, "aes128");

    issue(k192, 2'd1, 1, 0);
    chk("kat192_r12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    wait_done(13, "aes192");

    issue(k256, 2'd2, 1, 0);
    chk("kat256_r14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    @(negedge clk);
    chk("max128_err", 128'(err2), 128'(1));
    chk("max128_busy", 128'(busy2), 128'(0));
    chk("main_err_256", 128'(err), 128'(0));
    wait_done(15, "aes256");

    issue(k128, 2'd0, 0, 1);
    wait_done(11, "backpressure");
    rnd = 0;

    @(posedge clk);
    #1 start = 1;
    key_size = 2'd3;
    @(posedge clk);
    #1 start = 0;
    key_size = 2'd0;
    @(negedge clk);
    chk("bad_size_err", 128'(err), 128'(1));
    chk("bad_size_busy", 128'(busy), 128'(0));
    chk("bad_size_valid", 128'(rk_valid), 128'(0));
    @(negedge clk);
    chk("err_one_cycle", 128'(err), 128'(0));

    issue(k128, 2'd0, 1, 0);
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rk_valid && rk_index == 4'd5) break;
    end
    chk("reach_r5", 128'(c < 200), 128'(1));
    #1 rst_n = 0;
    @(negedge clk);
    chk("midreset_valid", 128'(rk_valid), 128'(0));
    chk("midreset_busy", 128'(busy), 128'(0));
    chk("midreset_data", rk_data, 128'(0));
    sb.delete();
    #1 rst_n = 1;
    repeat (3) @(negedge clk);
    chk("after_reset_valid", 128'(rk_valid), 128'(0));
    issue(k128, 2'd0, 1, 0);
    wait_done(11, "after_reset");

    for (int n = 0; n < 6; n++) begin
      logic [1:0] s;
      logic [255:0] k;
      s = 2'($urandom_range(0, 2));
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      issue(k, s, 0, 1);
      wait_done(4 * int'(s) / 2 + 11, "random");
    end
    rnd = 0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative, runtime-configurable AES key expansion engine for AES-128, AES-192 and AES-256.
- Generates one 32-bit schedule word per clock.
- Emits each 128-bit round key through a valid/ready handshake, round 0 first.
- Sits between the byte-serial input loader and the round datapath, replacing the single fixed-size key XOR of the first-generation core.

Parameters:
- MAX_KEY_BITS, 256, largest key size accepted (128, 192 or 256); key_size above it is rejected with err.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- key_size  input  2  0=128, 1=192, 2=256, 3=invalid.
- key_in  input  256  cipher key, MSB-first word packing; 128-bit keys occupy [255:128], 192-bit keys occupy [255:64]; unused low bits are ignored.
- rk_ready  input  1  consumer accepts rk_data this cycle.
- rk_valid  output  1  rk_data/rk_index valid.
- rk_data  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
- rk_index  output  4  round number r, 0..Nr.
- busy  output  1  high in GEN.
- done  output  1  one-cycle pulse at acceptance of the final round key.
- err  output  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - rk_valid, rk_data, rk_index, busy, done and err are all cleared to 0.
  - Word counter and key window are cleared.
  - This applies mid-generation too: any partial schedule is discarded, and no rk_valid or done follows.
- Key-size derived values:
  - Nk = 4, 6 or 8.
  - Nr = 10, 12 or 14.
  - Total words W = 4*(Nr+1) = 44, 52 or 60.
- IDLE, with start=1 at edge T:
  - If key_size==3, or the size exceeds MAX_KEY_BITS: err=1 during cycle T+1, state stays IDLE, no round keys are produced.
  - Otherwise: latch key_in and key_size, set word counter i=0, go to GEN (busy=1 from T+1).
- GEN produces one word per cycle unless stalled.
  - Stall condition: rk_valid && !rk_ready. While stalled, i, the window and the outputs are all frozen.
  - For i<Nk: w[i] = key word i.
  - For i>=Nk: temp = w[i-1].
    - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk],24'h0}.
    - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
    - Then w[i] = w[i-Nk] ^ temp.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- SubWord uses four instances of the team's combinational byte S-box.
- Key window: shift register of the last 8 words. w[i-Nk] is selected by Nk; w[i-1] is always the newest entry.
- Round-key emission:
  - On the edge that produces w[i] with i mod 4 == 3, load rk_data with the four words, set rk_index = i/4 and rk_valid = 1.
  - rk_valid holds until rk_valid && rk_ready; it clears on that edge unless a new round key loads on the same edge.
- Timing with rk_ready tied high:
  - Round r is valid in cycle T+4r+5.
  - The last round key is valid at T+45 (128), T+53 (192) or T+61 (256).
  - The round-key stream is back-to-back every 4 cycles.
- Completion:
  - After w[W-1] is produced, GEN stops generating and waits for the final handshake.
  - On the final handshake: done=1 for one cycle, then IDLE with busy=0.
  - A new start is accepted in the cycle after done.
- start while busy is ignored; no err is raised.
- key_in changes during GEN have no effect, because the key is latched at start.

Test Plan:
- AES-128, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - r0 equals the key at T+5.
  - r1 = a0fafe1788542cb123a339392a6c7605.
  - r10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+45, with done the same cycle.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - r12 = e98ba06f448c773c8ecc720401002202, rk_index=12.
  - Exactly 13 handshakes.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - r14 = fe4890d1e6188d0b046df344706c631e at T+61.
  - Exactly 15 handshakes.
- Backpressure: AES-128 with rk_ready low for 7 cycles at r3, and toggling randomly elsewhere:
  - rk_data/rk_index stay stable while stalled.
  - All 11 keys match the rk_ready=1 run.
  - done coincides with acceptance of r10.
- Errors and ignored starts:
  - key_size=3 -> err at T+1, no rk_valid, busy=0.
  - With MAX_KEY_BITS=128, key_size=2 -> err.
  - start during GEN is ignored.
- Reset mid-operation: reset=0 at the r5 emission cycle:
  - The next cycle has rk_valid=0, busy=0, rk_data=0.
  - A following AES-128 start reproduces the vector from r0.
